// File: rtl/lr35902_pkg.sv
// lr35902_pkg -- shared definitions for the lr35902 core slice.
//   bus_state_e          : bus-cycle sequencer states (IDLE/ADDR/STROBE/RELEASE)
//   FLAG_C/H/N/Z         : bit positions of the flags in the F register
//   TCYCLES_PER_MCYCLE   : T-cycles per M-cycle for the default strobe length
//   byte_lane()          : selects the low or high byte of a 16-bit word
package lr35902_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ADDR,
        BUS_STROBE,
        BUS_RELEASE
    } bus_state_e;

    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_H = 5;
    localparam int unsigned FLAG_N = 6;
    localparam int unsigned FLAG_Z = 7;

    localparam int unsigned TCYCLES_PER_MCYCLE = 4;

    function automatic logic [7:0] byte_lane(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/lr35902_bus_strobe_timer.sv
// lr35902_bus_strobe_timer -- times the strobe phase of one bus byte.
//   clk, reset_n  : clock, asynchronous active-low reset
//   active        : sequencer is in the STROBE state
//   bus_wait      : slave not ready (used only with LR35902_BUS_WAIT_EN)
//   strobe_done   : last strobe clock; the sequencer leaves STROBE after it
//   timeout       : last strobe clock ended by the wait limit (MAX_WAIT)
// The strobe phase is STROBE_CYCLES hold clocks followed by one sample clock,
// so STROBE_CYCLES=1 gives a 2-clock strobe and a 4-clock byte.
// Optional macro LR35902_BUS_WAIT_EN: bus_wait in the sample clock extends
// the strobe by one clock, up to MAX_WAIT extensions before timing out.
module lr35902_bus_strobe_timer #(
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned MAX_WAIT      = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic bus_wait,
    output logic strobe_done,
    output logic timeout
);

    logic [2:0] cnt_q;
    logic       at_end;
    logic       extend;

    assign at_end = active && (cnt_q == 3'(STROBE_CYCLES));

`ifdef LR35902_BUS_WAIT_EN
    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q;

    assign extend  = at_end && bus_wait && (wait_q != WAIT_W'(MAX_WAIT));
    assign timeout = at_end && bus_wait && (wait_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else if (!active) begin
            wait_q <= '0;
        end else if (extend) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end
`else
    localparam int unsigned unused_max_wait = MAX_WAIT;

    logic unused_bus_wait;
    assign unused_bus_wait = bus_wait;

    assign extend  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign strobe_done = at_end && !extend;

    // Counter parks at STROBE_CYCLES while the strobe is being extended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!active) begin
            cnt_q <= '0;
        end else if (!at_end) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/lr35902_bus_seq.sv
// lr35902_bus_seq -- bus-cycle sequencer between the CPU execution FSM and
// the memory/IO bus. Runs byte or little-endian word transfers as
// IDLE -> ADDR -> STROBE -> RELEASE (-> ADDR for the second byte).
//   clk, reset_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_write, req_word            : direction, byte/word size
//   req_adr, req_wdata             : start address, write data (low byte first)
//   rsp_valid, rsp_rdata, rsp_err  : one-clock completion pulse, read data
//                                    (byte reads zero-extended), wait timeout
//   adr, dout, ddrv, read, write   : bus address, write data, data drive, strobes
//   data                           : bus read data
//   bus_wait                       : slave not ready (LR35902_BUS_WAIT_EN only)
// Optional macro LR35902_BUS_WAIT_EN enables wait-state extension/timeout;
// without it bus_wait is ignored and rsp_err stays 0.
module lr35902_bus_seq
    import lr35902_pkg::*;
#(
    parameter int unsigned ADR_W         = 16,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned MAX_WAIT      = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_word,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [15:0]      req_wdata,
    output logic             rsp_valid,
    output logic [15:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [ADR_W-1:0] adr,
    input  logic [7:0]       data,
    output logic [7:0]       dout,
    output logic             ddrv,
    output logic             read,
    output logic             write,
    input  logic             bus_wait
);

    bus_state_e  state_q, state_d;

    logic        write_q;
    logic        word_q;
    logic        idx_q;
    logic        err_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_q;

    logic        strobe_active;
    logic        strobe_done;
    logic        timeout;
    logic        accept;
    logic        last_byte;
    logic        cur_write;
    logic        sample;
    logic        next_byte;

    assign req_ready     = (state_q == BUS_IDLE);
    assign accept        = req_valid && req_ready;
    assign strobe_active = (state_q == BUS_STROBE);
    assign last_byte     = !word_q || idx_q;

    lr35902_bus_strobe_timer #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .MAX_WAIT      (MAX_WAIT)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .active      (strobe_active),
        .bus_wait    (bus_wait),
        .strobe_done (strobe_done),
        .timeout     (timeout)
    );

    always_comb begin
        state_d   = state_q;
        cur_write = write_q;
        sample    = 1'b0;
        next_byte = 1'b0;
        unique case (state_q)
            BUS_IDLE: begin
                cur_write = req_write;
                if (req_valid) state_d = BUS_ADDR;
            end
            BUS_ADDR: begin
                state_d = BUS_STROBE;
            end
            BUS_STROBE: begin
                sample = strobe_done && !timeout;
                if (strobe_done) state_d = BUS_RELEASE;
            end
            BUS_RELEASE: begin
                if (last_byte || err_q) begin
                    state_d = BUS_IDLE;
                end else begin
                    state_d   = BUS_ADDR;
                    next_byte = 1'b1;
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each one changes on
    // the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BUS_IDLE;
            write_q   <= 1'b0;
            word_q    <= 1'b0;
            idx_q     <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            lo_q      <= '0;
            adr       <= '0;
            dout      <= '0;
            ddrv      <= 1'b0;
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            if (accept) begin
                write_q <= req_write;
                word_q  <= req_word;
                wdata_q <= req_wdata;
                idx_q   <= 1'b0;
                err_q   <= 1'b0;
                adr     <= req_adr;
                if (req_write) dout <= byte_lane(req_wdata, 1'b0);
            end

            if (next_byte) begin
                idx_q <= 1'b1;
                adr   <= adr + ADR_W'(1);
                if (write_q) dout <= byte_lane(wdata_q, 1'b1);
            end

            if (timeout) err_q <= 1'b1;

            if (sample && !write_q) begin
                if (!idx_q) lo_q <= data;
                if (last_byte) rsp_rdata <= idx_q ? {data, lo_q} : {8'h00, data};
            end

            // A timeout skips any remaining byte, so it completes the transfer.
            if (strobe_done && (last_byte || timeout)) begin
                rsp_valid <= 1'b1;
                rsp_err   <= timeout;
            end

            read  <= (state_d == BUS_STROBE) && !write_q;
            write <= (state_d == BUS_STROBE) && write_q;
            ddrv  <= (state_d != BUS_IDLE) && cur_write;
        end
    end

endmodule

// File: tb/tb_lr35902_bus_seq.sv
// tb_lr35902_bus_seq -- scoreboard bench for lr35902_bus_seq.
// Stimulus pushes expected responses and bus strobes into queues; monitors
// pop and compare when the DUT presents rsp_valid or a read/write strobe.
// Build with +define+LR35902_BUS_WAIT_EN to exercise wait states.
module tb_lr35902_bus_seq;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [15:0] req_adr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] adr;
    logic [7:0]  data;
    logic [7:0]  dout;
    logic        ddrv;
    logic        read;
    logic        write;
    logic        bus_wait;

    logic [7:0]  mem [0:65535];

    typedef struct {
        logic [15:0] rdata;
        logic        chk;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          len;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t rd_q[$];
    bus_t wr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;

    lr35902_bus_seq #(
        .ADR_W         (16),
        .STROBE_CYCLES (1),
        .MAX_WAIT      (15)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_word  (req_word),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .adr       (adr),
        .data      (data),
        .dout      (dout),
        .ddrv      (ddrv),
        .read      (read),
        .write     (write),
        .bus_wait  (bus_wait)
    );

    assign data = mem[adr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_q.size()), 32'd1);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                if (e.chk) check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            end
        end
    end

    // Read strobe monitor: address and strobe width
    logic        rd_prev = 1'b0;
    logic [15:0] rd_adr  = '0;
    int          rd_len  = 0;
    always @(negedge clk) begin
        if (read && write) overlap++;
        if (read) begin
            if (!rd_prev) rd_adr = adr;
            rd_len++;
        end else if (rd_prev) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", 32'(rd_q.size()), 32'd1);
            end else begin
                bus_t b;
                b = rd_q.pop_front();
                check("read_adr", 32'(rd_adr), 32'(b.a));
                check("read_len", 32'(rd_len), 32'(b.len));
            end
            rd_len = 0;
        end
        rd_prev = read;
    end

    // Write strobe monitor: address, data and drive at strobe start
    logic wr_prev = 1'b0;
    always @(negedge clk) begin
        if (write && !wr_prev) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(wr_q.size()), 32'd1);
            end else begin
                bus_t b;
                b = wr_q.pop_front();
                check("write_adr", 32'(adr), 32'(b.a));
                check("write_dout", 32'(dout), 32'(b.d));
                check("write_ddrv", 32'(ddrv), 32'd1);
            end
        end
        wr_prev = write;
    end

    task automatic push_rd(input logic [15:0] a, input int len);
        bus_t b;
        b.a = a; b.d = 8'h00; b.len = len;
        rd_q.push_back(b);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        bus_t b;
        b.a = a; b.d = d; b.len = 0;
        wr_q.push_back(b);
    endtask

    // Presents a request, waits (bounded) for acceptance, returns #1 after the accept edge.
    task automatic issue(input logic wr, input logic wd, input logic [15:0] a,
                         input logic [15:0] wdat, input logic push,
                         input logic [15:0] exp_rd, input logic chk_rd,
                         input logic exp_err, input int lat, input logic hold,
                         output int acc);
        int t;
        rsp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_word  = wd;
        req_adr   = a;
        req_wdata = wdat;
        t = 0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) begin
            e.rdata = exp_rd; e.chk = chk_rd; e.err = exp_err; e.lat = lat; e.acc = acc;
            rsp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rsp_q.size() + rd_q.size() + wr_q.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(rsp_q.size() + rd_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        int acc1;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_word  = 1'b0;
        req_adr   = '0;
        req_wdata = '0;
        bus_wait  = 1'b0;
        mem[16'h1234] = 8'hA5;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h2000] = 8'h3C;
        mem[16'h3000] = 8'h99;
        mem[16'h3001] = 8'h66;

        repeat (2) @(negedge clk);
        check("reset_adr", 32'(adr), 32'h0);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_strobes", {28'h0, ddrv, read, write, rsp_valid}, 32'h0);
        check("reset_rsp", {15'h0, rsp_err, rsp_rdata}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);

        // Byte read 0x1234 -> 0x00A5
        push_rd(16'h1234, 2);
        issue(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 16'h00A5, 1'b1, 1'b0, 3, 1'b0, acc0);
        drain();

        // Word write 0xBEEF to 0xC000
        push_wr(16'hC000, 8'hEF);
        push_wr(16'hC001, 8'hBE);
        issue(1'b1, 1'b1, 16'hC000, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 1'b0, 7, 1'b0, acc0);
        drain();

        // Word read across the address wrap
        push_rd(16'hFFFF, 2);
        push_rd(16'h0000, 2);
        issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h2211, 1'b1, 1'b0, 7, 1'b0, acc0);
        drain();

        // Byte write
        push_wr(16'h0010, 8'h5A);
        issue(1'b1, 1'b0, 16'h0010, 16'h775A, 1'b1, 16'h0000, 1'b0, 1'b0, 3, 1'b0, acc0);
        drain();

        // Back-to-back read then write with req_valid held
        push_rd(16'h2000, 2);
        push_wr(16'h2001, 8'h77);
        issue(1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h003C, 1'b1, 1'b0, 3, 1'b1, acc0);
        issue(1'b1, 1'b0, 16'h2001, 16'h0077, 1'b1, 16'h0000, 1'b0, 1'b0, 3, 1'b0, acc1);
        check("b2b_gap", 32'(acc1 - acc0), 32'd5);
        drain();

        // Idle with req_valid=0: bus outputs hold
        repeat (3) @(negedge clk);
        check("idle_adr", 32'(adr), 32'h2001);
        check("idle_dout", 32'(dout), 32'h77);
        check("idle_strobes", {29'h0, ddrv, read, write}, 32'h0);

`ifdef LR35902_BUS_WAIT_EN
        // bus_wait high for 3 sample clocks: strobe 2+3 clocks
        push_rd(16'h3000, 5);
        issue(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h0099, 1'b1, 1'b0, 6, 1'b0, acc0);
        repeat (2) @(posedge clk);
        #1 bus_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_wait = 1'b0;
        drain();

        // bus_wait stuck: 15 extensions then timeout
        bus_wait = 1'b1;
        push_rd(16'h3001, 17);
        issue(1'b0, 1'b0, 16'h3001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 18, 1'b0, acc0);
        drain();
        bus_wait = 1'b0;
`else
        // bus_wait is ignored in this build
        bus_wait = 1'b1;
        push_rd(16'h3000, 2);
        issue(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'h0099, 1'b1, 1'b0, 3, 1'b0, acc0);
        drain();
        bus_wait = 1'b0;
`endif

        // Reset mid word write: outputs clear at once, no response
        issue(1'b1, 1'b1, 16'h4000, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, acc0);
        check("abort_adr_before", 32'(adr), 32'h4000);
        check("abort_ddrv_before", 32'(ddrv), 32'd1);
        check("abort_dout_before", 32'(dout), 32'h34);
        #2 reset_n = 1'b0;
        #1;
        check("abort_adr", 32'(adr), 32'h0);
        check("abort_dout", 32'(dout), 32'h0);
        check("abort_strobes", {28'h0, ddrv, read, write, rsp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_idle_strobes", {29'h0, ddrv, read, write}, 32'h0);

        check("no_overlap", 32'(overlap), 32'd0);
        check("final_queues", 32'(rsp_q.size() + rd_q.size() + wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lr35902_bus_seq.md
Name: lr35902_bus_seq

Overview:
- Bus-cycle sequencer for the next-generation lr35902 core. It replaces the per-state T-cycle bus handling that is hard-coded inside the CPU.
- The core issues byte or 16-bit (two-byte, little-endian) read/write requests over a valid/ready handshake. The block drives the external adr/data/read/write/ddrv bus with configurable strobe length and optional wait-state support.
- Sits between the CPU execution FSM and the memory/IO bus fabric.

Parameters:
- ADR_W, 16, address width; the word second-byte address wraps modulo 2^ADR_W.
- STROBE_CYCLES, 1, clocks read/write strobe is held before sampling/release (1..7); default gives 4 clocks per byte (one M-cycle).
- MAX_WAIT, 15, maximum wait-extension clocks before abort (only with wait feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_write  in  1  1=write, 0=read
- req_word  in  1  1=two bytes (adr, adr+1), 0=one byte
- req_adr  in  ADR_W  start address
- req_wdata  in  16  write data; low byte first
- rsp_valid  out  1  one-clock pulse when the transfer completes
- rsp_rdata  out  16  read data; byte read zero-extends
- rsp_err  out  1  valid with rsp_valid; wait timeout
- adr  out  ADR_W  bus address
- data  in  8  bus read data
- dout  out  8  bus write data
- ddrv  out  1  drive dout onto bus
- read  out  1  read strobe
- write  out  1  write strobe
- bus_wait  in  1  slave not ready (wait feature only)

Behaviour:
- Reset (async, reset_n=0): adr=0, dout=0, ddrv=0, read=0, write=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM to IDLE, byte index=0. Reset mid-transfer aborts with no rsp_valid.
- req_ready=1 only in IDLE. Accept on req_valid&&req_ready; all request fields are latched at accept.
- FSM: IDLE -> ADDR -> STROBE -> RELEASE -> (ADDR for second byte | IDLE).
- ADDR (1 clk):
  - adr = start address or start+1.
  - Write: dout = selected byte, ddrv=1.
  - Read: ddrv=0.
- STROBE (STROBE_CYCLES clks):
  - read or write = 1.
  - Read: data is sampled into the byte lane at the last strobe clock.
- RELEASE (1 clk):
  - read=0, write=0; ddrv cleared on leaving RELEASE.
  - After the final byte, rsp_valid=1 for exactly one clock, concurrent with returning to IDLE.
- Latency, byte, STROBE_CYCLES=1: accept edge k; read=1 edges k+1..k+2; rsp_valid high in cycle k+3. Word = 8 clocks.
- Back-to-back: a new request may be accepted in the cycle after rsp_valid. read and write are never both 1.
- Word address wrap: with ADR_W=16, 0xFFFF then 0x0000.
- Requests with req_valid=0 leave all bus outputs stable.

Optional Feature:
- Macro LR35902_BUS_WAIT_EN.
- Defined:
  - bus_wait is sampled in the last STROBE clock; if 1, the strobe is held one more clock and data is not sampled.
  - A counter counts extensions. Reaching MAX_WAIT ends the transfer: strobe is dropped, RELEASE runs, rsp_valid=1 with rsp_err=1, remaining bytes are skipped, and rsp_rdata is undefined.
- Undefined: bus_wait is ignored and rsp_err is constant 0.

Decomposition:
- Shared package lr35902_pkg: FSM state encoding (IDLE/ADDR/STROBE/RELEASE), flag bit indices C/H/N/Z, and the default T-cycles-per-M-cycle constant (4).
- One natural sub-module: lr35902_bus_strobe_timer, the strobe/wait counter that produces the "strobe done" and "timeout" signals.

Test Plan:
- Byte read from 0x1234, data=0xA5, STROBE_CYCLES=1: adr=0x1234, read high exactly 2 clks, rsp_valid in 4th clk after accept, rsp_rdata=0x00A5.
- Word write 0xBEEF to 0xC000: bus writes 0xEF@0xC000 then 0xBE@0xC001, ddrv high during each byte, 8 clks total, one rsp_valid.
- Word read at 0xFFFF with data 0x11 then 0x22: addresses 0xFFFF, 0x0000; rsp_rdata=0x2211.
- With LR35902_BUS_WAIT_EN, bus_wait high 3 clks: strobe lengthened 3 clks, correct data, rsp_err=0. Held permanently with MAX_WAIT=15: rsp_err=1 after 15 extensions.
- reset_n pulsed low mid word write: all bus outputs 0 immediately, no rsp_valid, req_ready=1 after release.
- Back-to-back read then write with req_valid held: no gap beyond the one IDLE clock; read/write never overlap.
